// File: rtl/waveform_pkg.sv
// Shared constants and capture state type for the waveform code generator.
package waveform_pkg;

  localparam logic [3:0] CODE_BG     = 4'h0;
  localparam logic [3:0] CODE_FROZEN = 4'h1;
  localparam logic [3:0] CODE_LIVE   = 4'h2;
  localparam logic [3:0] CODE_AXIS   = 4'h5;
  localparam logic [3:0] CODE_GRID   = 4'h6;
  localparam logic [3:0] CODE_BLANK  = 4'h8;

  localparam logic [9:0] CENTER_Y = 10'd240;

  typedef enum logic {
    CAPTURE = 1'b0,
    FULL    = 1'b1
  } cap_state_t;

endpackage

// File: rtl/waveform_column_ram.sv
// Two-bank column store: one write port for capture, one registered read port for display.
module waveform_column_ram #(
  parameter int DEPTH = 1280,
  parameter int AW    = $clog2(DEPTH)
) (
  input  logic          clk,
  input  logic          we,
  input  logic [AW-1:0] waddr,
  input  logic [15:0]   wdata,
  input  logic [AW-1:0] raddr,
  output logic [15:0]   rdata
);

  logic [15:0] mem [DEPTH];

  always_ff @(posedge clk) begin
    if (we) mem[waddr] <= wdata;
    rdata <= mem[raddr];
  end

endmodule

// File: rtl/waveform_code_gen.sv
// Audio min/max capture into a double-buffered column RAM and per-pixel colour code lookup.
// state   | meaning
// CAPTURE | accepting samples, column advances every DECIM samples
// FULL    | last column written, samples dropped until an unfrozen frame_start swaps banks
module waveform_code_gen
  import waveform_pkg::*;
#(
  parameter int H_ACTIVE = 640,
  parameter int V_ACTIVE = 480,
  parameter int DECIM    = 16
) (
  input  logic        Clk,
  input  logic        Reset_n,
  input  logic        sample_valid,
  input  logic [15:0] sample_data,
  input  logic        frame_start,
  input  logic        freeze,
  input  logic        pixel_valid,
  input  logic [9:0]  DrawX,
  input  logic [9:0]  DrawY,
  output logic [3:0]  Colorcode,
  output logic        code_valid
);

  localparam int DW = $clog2(DECIM);
  localparam int AW = $clog2(2 * H_ACTIVE);
  localparam logic [DW-1:0] DEC_LAST = DW'(DECIM - 1);
  localparam logic [9:0]    COL_LAST = 10'(H_ACTIVE - 1);

  cap_state_t state, state_next;
  logic [9:0] col, col_eff;
  logic [DW-1:0] dec, dec_eff;
  logic bank, bank_next, read_valid;
  logic signed [7:0] smp, cur_min, cur_max, new_min, new_max;
  logic accept, swap, we;
  logic [AW-1:0] waddr, raddr;
  logic [15:0] rdata;
  logic [7:0] unused_lsb;

  assign smp = sample_data[15:8];
  assign unused_lsb = sample_data[7:0];

  always_ff @(posedge Clk or negedge Reset_n) begin
    if (!Reset_n) state <= CAPTURE;
    else          state <= state_next;
  end

  always_comb begin
    state_next = state;
    accept     = 1'b0;
    swap       = 1'b0;
    case (state)
      CAPTURE: begin
        accept = sample_valid;
        if (sample_valid && dec == DEC_LAST && col == COL_LAST) state_next = FULL;
      end
      FULL: begin
        if (frame_start && !freeze) begin
          swap       = 1'b1;
          accept     = sample_valid;
          state_next = CAPTURE;
        end
      end
      default: state_next = CAPTURE;
    endcase
  end

  // On a swap the coincident sample is treated as sample 0 of column 0 in the new bank.
  always_comb begin
    col_eff   = swap ? 10'd0 : col;
    dec_eff   = swap ? '0 : dec;
    bank_next = swap ? ~bank : bank;
    new_min   = (dec_eff == '0 || smp < cur_min) ? smp : cur_min;
    new_max   = (dec_eff == '0 || smp > cur_max) ? smp : cur_max;
    we        = accept && dec_eff == DEC_LAST;
    waddr     = AW'(col_eff) + (bank_next ? AW'(H_ACTIVE) : AW'(0));
  end

  always_ff @(posedge Clk or negedge Reset_n) begin
    if (!Reset_n) begin
      col        <= 10'd0;
      dec        <= '0;
      bank       <= 1'b0;
      read_valid <= 1'b0;
      cur_min    <= '0;
      cur_max    <= '0;
    end else begin
      bank <= bank_next;
      col  <= col_eff;
      dec  <= dec_eff;
      if (swap) read_valid <= 1'b1;
      if (accept) begin
        cur_min <= new_min;
        cur_max <= new_max;
        dec     <= dec_eff + DW'(1);
        if (we && col_eff != COL_LAST) col <= col_eff + 10'd1;
      end
    end
  end

  waveform_column_ram #(.DEPTH(2 * H_ACTIVE), .AW(AW)) u_ram (
    .clk  (Clk),
    .we   (we),
    .waddr(waddr),
    .wdata({new_max, new_min}),
    .raddr(raddr),
    .rdata(rdata)
  );

  logic x_in, in_range;
  logic [3:0] base;
  logic [3:0] base_q;
  logic trace_en_q, freeze_q;
  logic [9:0] drawy_q, y_min, y_max;

  always_comb begin
    x_in     = 32'(DrawX) < H_ACTIVE;
    in_range = pixel_valid && x_in && 32'(DrawY) < V_ACTIVE;
    raddr    = x_in ? AW'(DrawX) + (bank ? AW'(0) : AW'(H_ACTIVE)) : AW'(0);
    if (!in_range)                           base = CODE_BLANK;
    else if (DrawY == CENTER_Y)              base = CODE_AXIS;
    else if (DrawX[5:0] == 6'd0 || DrawY[5:0] == 6'd0) base = CODE_GRID;
    else                                     base = CODE_BG;
  end

  always_ff @(posedge Clk or negedge Reset_n) begin
    if (!Reset_n) begin
      base_q     <= CODE_BG;
      trace_en_q <= 1'b0;
      freeze_q   <= 1'b0;
      drawy_q    <= 10'd0;
      code_valid <= 1'b0;
    end else begin
      base_q     <= base;
      trace_en_q <= in_range && read_valid;
      freeze_q   <= freeze;
      drawy_q    <= DrawY;
      code_valid <= pixel_valid;
    end
  end

  // The RAM read register is the pipeline stage, so the final trace overlay uses only registered terms.
  assign y_min = CENTER_Y - {{2{rdata[15]}}, rdata[15:8]};
  assign y_max = CENTER_Y - {{2{rdata[7]}}, rdata[7:0]};
  assign Colorcode = (trace_en_q && drawy_q >= y_min && drawy_q <= y_max) ?
                     (freeze_q ? CODE_FROZEN : CODE_LIVE) : base_q;

endmodule
